// File: rtl/a25_wishbone_post_buf.sv
// Posted-write buffer between an Amber core port and the wishbone arbiter: writes are queued and acked at once, reads wait for the queue to drain.
// Optional macro A25_WBUF_STALL_CNT_EN adds o_stall_cnt, a saturating count of cycles a write is stalled on a full queue.
module a25_wishbone_post_buf #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic                i_write,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_ack,
    output logic                o_valid,
    input  logic                i_accepted,
    output logic                o_write,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_be,
    output logic [ADDR_W-1:0]   o_addr,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic                i_rdata_valid,
    output logic                o_empty
`ifdef A25_WBUF_STALL_CNT_EN
    ,
    output logic [15:0]         o_stall_cnt
`endif
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    logic [ADDR_W-1:0]  addr_mem  [DEPTH];
    logic [DATA_W-1:0]  wdata_mem [DEPTH];
    logic [BE_W-1:0]    be_mem    [DEPTH];

    logic full;
    logic empty;
    logic idle;
    logic push;
    logic pop;
    logic read_issue;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign idle       = (state == IDLE);
    assign push       = i_req & i_write & ~full & idle;
    assign pop        = o_valid & i_accepted & ~empty;
    assign read_issue = i_req & ~i_write & empty & idle;
    assign o_rdata    = i_rdata;
    assign o_empty    = empty & idle;

    // Control state: occupancy, pointers and read-tracking FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            state  <= IDLE;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr]  <= i_addr;
            wdata_mem[wr_ptr] <= i_wdata;
            be_mem[wr_ptr]    <= i_be;
        end
    end

    always_comb begin
        state_next = state;
        o_ack      = push;
        o_valid    = 1'b0;
        o_write    = 1'b1;
        o_addr     = addr_mem[rd_ptr];
        o_wdata    = wdata_mem[rd_ptr];
        o_be       = be_mem[rd_ptr];
        case (state)
            IDLE: begin
                if (!empty) begin
                    o_valid = 1'b1;
                end else if (read_issue) begin
                    o_valid = 1'b1;
                    o_write = 1'b0;
                    o_addr  = i_addr;
                    o_wdata = i_wdata;
                    o_be    = {BE_W{1'b1}};
                    if (i_accepted) begin
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (i_rdata_valid) begin
                    o_ack      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef A25_WBUF_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_stall_cnt <= '0;
        end else if (i_req && i_write && full && (o_stall_cnt != 16'hffff)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_a25_wishbone_post_buf.sv
// Directed bench for a25_wishbone_post_buf (DEPTH=4, DATA_W=128): writes, full stall, read ordering, wrap, reset in RD_WAIT.
module tb_a25_wishbone_post_buf;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req;
    logic         i_write;
    logic [127:0] i_wdata;
    logic [15:0]  i_be;
    logic [31:0]  i_addr;
    logic [127:0] o_rdata;
    logic         o_ack;
    logic         o_valid;
    logic         i_accepted;
    logic         o_write;
    logic [127:0] o_wdata;
    logic [15:0]  o_be;
    logic [31:0]  o_addr;
    logic [127:0] i_rdata;
    logic         i_rdata_valid;
    logic         o_empty;
`ifdef A25_WBUF_STALL_CNT_EN
    logic [15:0]  o_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    a25_wishbone_post_buf #(.DATA_W(128), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_write(i_write), .i_wdata(i_wdata),
        .i_be(i_be), .i_addr(i_addr), .o_rdata(o_rdata), .o_ack(o_ack), .o_valid(o_valid),
        .i_accepted(i_accepted), .o_write(o_write), .o_wdata(o_wdata), .o_be(o_be),
        .o_addr(o_addr), .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid), .o_empty(o_empty)
`ifdef A25_WBUF_STALL_CNT_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Apply inputs on the falling edge and let combinational outputs settle before checking
    task automatic drive(input logic req, input logic wr, input logic [31:0] addr, input logic acc);
        @(negedge clk);
        i_req      = req;
        i_write    = wr;
        i_addr     = addr;
        i_wdata    = {96'h0, 32'hD000_0000 | addr};
        i_accepted = acc;
        #1;
    endtask

    initial begin
        reset = 1'b1; i_req = 0; i_write = 0; i_wdata = '0; i_be = 16'hffff; i_addr = '0;
        i_accepted = 0; i_rdata = '0; i_rdata_valid = 0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_ack", o_ack, 0);
        check("rst_empty", o_empty, 1);
        @(negedge clk); reset = 1'b0;

        // Single write, drained immediately
        drive(1, 1, 32'h100, 1);
        check("w1_ack", o_ack, 1);
        check("w1_valid_same", o_valid, 0);
        drive(0, 0, 32'h0, 1);
        check("w1_valid", o_valid, 1);
        check("w1_write", o_write, 1);
        check("w1_addr", o_addr, 32'h100);
        check("w1_data", o_wdata, {96'h0, 32'hD000_0100});
        drive(0, 0, 32'h0, 0);
        check("w1_empty", o_empty, 1);
        check("w1_valid_off", o_valid, 0);

        // Five writes with the bus stalled: fifth one waits for space
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h300 + i, 0);
            check($sformatf("fill_ack%0d", i), o_ack, 1);
        end
        drive(1, 1, 32'h304, 0);
        check("full_noack", o_ack, 0);
        check("full_head", o_addr, 32'h300);
        drive(1, 1, 32'h304, 1);
        check("full_pop_noack", o_ack, 0);
        drive(1, 1, 32'h304, 0);
        check("full_late_ack", o_ack, 1);
        check("full_head2", o_addr, 32'h301);
        for (int i = 1; i < 5; i++) begin
            drive(0, 0, 32'h0, 1);
            check($sformatf("drain_valid%0d", i), o_valid, 1);
            check($sformatf("drain_addr%0d", i), o_addr, 32'h300 + i);
        end
        drive(0, 0, 32'h0, 0);
        check("drain_empty", o_empty, 1);

        // Read behind a queued write
        drive(1, 1, 32'h200, 0);
        check("rw_wack", o_ack, 1);
        drive(1, 0, 32'h204, 0);
        check("rw_head_write", o_write, 1);
        check("rw_head_addr", o_addr, 32'h200);
        check("rw_noack", o_ack, 0);
        drive(1, 0, 32'h204, 1);
        check("rw_still_write", o_write, 1);
        drive(1, 0, 32'h204, 1);
        check("rd_valid", o_valid, 1);
        check("rd_write", o_write, 0);
        check("rd_addr", o_addr, 32'h204);
        check("rd_be", o_be, 16'hffff);
        check("rd_noack", o_ack, 0);
        drive(1, 0, 32'h204, 0);
        check("rdw_valid", o_valid, 0);
        check("rdw_empty", o_empty, 0);
        check("rdw_noack", o_ack, 0);
        drive(1, 1, 32'h500, 0);
        check("rdw_push_blocked", o_ack, 0);
        drive(1, 0, 32'h204, 0);
        i_rdata = 128'hDEAD; i_rdata_valid = 1; #1;
        check("rd_ack", o_ack, 1);
        check("rd_data", o_rdata, 128'hDEAD);
        drive(0, 0, 32'h0, 0);
        i_rdata_valid = 1; #1;
        check("stray_idle_noack", o_ack, 0);
        check("rd_done_empty", o_empty, 1);
        i_rdata_valid = 0;

        // Steady push+pop at two entries across the pointer wrap
        drive(1, 1, 32'h600, 0);
        check("pp_ack0", o_ack, 1);
        drive(1, 1, 32'h601, 0);
        check("pp_ack1", o_ack, 1);
        for (int i = 2; i < 10; i++) begin
            drive(1, 1, 32'h600 + i, 1);
            check($sformatf("pp_ack%0d", i), o_ack, 1);
            check($sformatf("pp_head%0d", i), o_addr, 32'h600 + i - 2);
        end
        drive(0, 0, 32'h0, 1);
        check("pp_tail8", o_addr, 32'h608);
        drive(0, 0, 32'h0, 1);
        check("pp_tail9", o_addr, 32'h609);
        check("pp_tail_data", o_wdata, {96'h0, 32'hD000_0609});
        drive(0, 0, 32'h0, 0);
        check("pp_empty", o_empty, 1);

        // Reset while a read is outstanding
        drive(1, 0, 32'h400, 1);
        check("r5_issue", o_valid, 1);
        drive(0, 0, 32'h0, 0);
        check("r5_wait_empty", o_empty, 0);
        reset = 1'b1; #1;
        check("r5_rst_valid", o_valid, 0);
        check("r5_rst_empty", o_empty, 1);
        @(negedge clk); reset = 1'b0;
        i_rdata = 128'hBEEF; i_rdata_valid = 1; #1;
        check("r5_stray_noack", o_ack, 0);
        check("r5_empty", o_empty, 1);
        i_rdata_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
